// File: rtl/odometer_scan_master.sv
// Odometer scan master: shifts a 7-bit control word out, triggers a measurement, waits on the
// stress handshake and reads back a 10-bit count. Optional wait timeout: ODO_SCAN_TIMEOUT_EN.
`timescale 1ns/1ps
module odometer_scan_master #(
    parameter int unsigned DIV     = 4,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       go_i,
    input  logic [6:0] cfg_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [9:0] result_o,
    output logic       timeout_flag_o,
    output logic       scan_in_o,
    output logic       scan_clk1_o,
    output logic       load_o,
    output logic       meas_trig_o,
    output logic       scan_clk2_o,
    input  logic       meas_stress_i,
    input  logic       scan_out_i
);
    localparam logic [7:0] HalfLast = 8'(DIV - 1);

    typedef enum logic [2:0] {
        StIdle, StCfgShift, StLoadP, StTrig, StWaitHi, StWaitLo, StRead, StFin
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] half_cnt_q, half_cnt_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic       phase_q, phase_d;
    logic [6:0] cfg_q, cfg_d;
    logic [9:0] shadow_q, shadow_d;
    logic [9:0] result_q, result_d;
    logic [1:0] stress_sync_q, scan_sync_q;
    logic [6:0] outs_q, outs_d;
    logic       stress_s, scan_s, half_done, tmo_hit;

    assign stress_s  = stress_sync_q[1];
    assign scan_s    = scan_sync_q[1];
    assign half_done = (half_cnt_q == HalfLast);

    // Packed as {busy, done, scan_in, scan_clk1, load, meas_trig, scan_clk2}.
    function automatic logic [6:0] decode(input state_e st, input logic ph, input logic msb);
        logic [6:0] o;
        o    = '0;
        o[6] = (st != StIdle) && (st != StFin);
        o[5] = (st == StFin);
        o[4] = (st == StCfgShift) && msb;
        o[3] = (st == StCfgShift) && ph;
        o[2] = (st == StLoadP) && !ph;
        o[1] = (st == StTrig);
        o[0] = (st == StRead) && ph;
        return o;
    endfunction

`ifdef ODO_SCAN_TIMEOUT_EN
    localparam logic [15:0] TmoLast = 16'(TIMEOUT - 1);
    logic [15:0] tmo_cnt_q;
    logic        tflag_q;
    logic        in_wait;

    assign in_wait        = (state_q == StWaitHi) || (state_q == StWaitLo);
    assign tmo_hit        = in_wait && (tmo_cnt_q == TmoLast);
    assign timeout_flag_o = tflag_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt_q <= '0;
            tflag_q   <= 1'b0;
        end else begin
            tmo_cnt_q <= in_wait ? tmo_cnt_q + 16'd1 : '0;
            if (state_q == StIdle && go_i) begin
                tflag_q <= 1'b0;
            end else if (tmo_hit) begin
                tflag_q <= 1'b1;
            end
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo     = ^TIMEOUT;
    assign tmo_hit        = 1'b0;
    assign timeout_flag_o = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        half_cnt_d = half_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        phase_d    = phase_q;
        cfg_d      = cfg_q;
        shadow_d   = shadow_q;
        result_d   = result_q;
        unique case (state_q)
            StIdle: begin
                if (go_i) begin
                    state_d  = StCfgShift;
                    cfg_d    = cfg_i;
                    shadow_d = '0;
                end
            end
            StCfgShift: begin
                half_cnt_d = half_cnt_q + 8'd1;
                if (half_done) begin
                    half_cnt_d = '0;
                    phase_d    = ~phase_q;
                    if (phase_q) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        cfg_d     = {cfg_q[5:0], 1'b0};
                        if (bit_cnt_q == 4'd6) begin
                            state_d   = StLoadP;
                            bit_cnt_d = '0;
                        end
                    end
                end
            end
            StLoadP: begin
                half_cnt_d = half_cnt_q + 8'd1;
                if (half_done) begin
                    half_cnt_d = '0;
                    phase_d    = ~phase_q;
                    if (phase_q) begin
                        state_d = StTrig;
                    end
                end
            end
            StTrig: begin
                half_cnt_d = half_cnt_q + 8'd1;
                if (half_done) begin
                    half_cnt_d = '0;
                    state_d    = StWaitHi;
                end
            end
            StWaitHi: begin
                if (tmo_hit) begin
                    state_d = StRead;
                end else if (stress_s) begin
                    state_d = StWaitLo;
                end
            end
            StWaitLo: begin
                if (tmo_hit) begin
                    state_d    = StRead;
                    half_cnt_d = '0;
                    bit_cnt_d  = '0;
                    phase_d    = 1'b0;
                end else if (!phase_q) begin
                    phase_d = !stress_s;
                end else begin
                    // Settling delay of two half-periods after the stress flag drops.
                    half_cnt_d = half_cnt_q + 8'd1;
                    if (half_done) begin
                        half_cnt_d = '0;
                        bit_cnt_d  = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd1) begin
                            state_d   = StRead;
                            bit_cnt_d = '0;
                            phase_d   = 1'b0;
                        end
                    end
                end
            end
            StRead: begin
                half_cnt_d = half_cnt_q + 8'd1;
                if (half_done) begin
                    half_cnt_d = '0;
                    phase_d    = ~phase_q;
                    if (phase_q) begin
                        shadow_d  = {scan_s, shadow_q[9:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd9) begin
                            state_d   = StFin;
                            bit_cnt_d = '0;
                            result_d  = {scan_s, shadow_q[9:1]};
                        end
                    end
                end
            end
            StFin: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are registered from next-state so the odometer never sees decode glitches.
    assign outs_d = decode(state_d, phase_d, cfg_d[6]);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            half_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            phase_q       <= 1'b0;
            cfg_q         <= '0;
            shadow_q      <= '0;
            result_q      <= '0;
            stress_sync_q <= '0;
            scan_sync_q   <= '0;
            outs_q        <= '0;
        end else begin
            state_q       <= state_d;
            half_cnt_q    <= half_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            phase_q       <= phase_d;
            cfg_q         <= cfg_d;
            shadow_q      <= shadow_d;
            result_q      <= result_d;
            stress_sync_q <= {stress_sync_q[0], meas_stress_i};
            scan_sync_q   <= {scan_sync_q[0], scan_out_i};
            outs_q        <= outs_d;
        end
    end

    assign {busy_o, done_o, scan_in_o, scan_clk1_o, load_o, meas_trig_o, scan_clk2_o} = outs_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_odometer_scan_master.sv
// Scoreboard bench for odometer_scan_master: lane 0 runs DIV=4, lane 1 runs DIV=2,
// each with a behavioural odometer model; a per-lane monitor checks every DONE.
`timescale 1ns/1ps
module tb_odometer_scan_master;
    localparam int unsigned TMO = 100;
    localparam int BBusy = 7, BDone = 6, BTflag = 5, BSin = 4;
    localparam int BClk1 = 3, BLoad = 2, BTrig = 1, BClk2 = 0;

    typedef struct {
        int         lane;
        logic [9:0] result;
        logic [6:0] ctrl;
        logic       tflag;
    } exp_t;

    exp_t       sb_q[$];
    int         checks = 0;
    int         errors = 0;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       go [2];
    logic [6:0] cfg [2];
    logic [9:0] model_val [2];
    logic       stress_en [2];
    logic [7:0] outs [2];
    logic [9:0] res [2];

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_lane
        localparam int unsigned D = (g == 0) ? 4 : 2;
        logic busy, done, tflag, sin, sclk1, load, trig, sclk2;
        logic stress = 1'b0;
        logic sout = 1'b0;
        logic [9:0] result;

        odometer_scan_master #(.DIV(D), .TIMEOUT(TMO)) u_dut (
            .clk_i          (clk),
            .rst_ni         (rst_n),
            .go_i           (go[g]),
            .cfg_i          (cfg[g]),
            .busy_o         (busy),
            .done_o         (done),
            .result_o       (result),
            .timeout_flag_o (tflag),
            .scan_in_o      (sin),
            .scan_clk1_o    (sclk1),
            .load_o         (load),
            .meas_trig_o    (trig),
            .scan_clk2_o    (sclk2),
            .meas_stress_i  (stress),
            .scan_out_i     (sout)
        );

        assign outs[g] = {busy, done, tflag, sin, sclk1, load, trig, sclk2};
        assign res[g]  = result;

        logic [6:0] ctrl_sh, ctrl;
        logic p_clk1, p_clk2, p_load, p_trig, p_sin, p_done;
        int n_clk1, n_clk2, n_load, wid_err, sin_err;
        int hi1, lo1, hi2, lo2, ld_hi, st_ph, st_cnt, bit_idx;
        exp_t e;

        // Odometer model plus DONE monitor, both sampling on the falling edge.
        always @(negedge clk) begin
            if (!rst_n) begin
                n_clk1 = 0; n_clk2 = 0; n_load = 0; wid_err = 0; sin_err = 0;
                hi1 = 0; lo1 = 0; hi2 = 0; lo2 = 0; ld_hi = 0;
                st_ph = 0; st_cnt = 0; bit_idx = 0;
                ctrl_sh = '0; ctrl = '0; stress = 1'b0; sout = 1'b0;
                p_clk1 = 0; p_clk2 = 0; p_load = 0; p_trig = 0; p_sin = 0; p_done = 0;
            end else begin
                if (sclk1) begin
                    if (!p_clk1) begin
                        if (n_clk1 > 0 && lo1 != D) wid_err++;
                        n_clk1++;
                        ctrl_sh = {ctrl_sh[5:0], sin};
                        hi1 = 0;
                    end else if (sin != p_sin) begin
                        sin_err++;
                    end
                    hi1++;
                end else begin
                    if (p_clk1) begin
                        if (hi1 != D) wid_err++;
                        lo1 = 0;
                    end
                    lo1++;
                end

                if (load) begin
                    if (!p_load) begin
                        ctrl = ctrl_sh;
                        n_load++;
                        ld_hi = 0;
                    end
                    ld_hi++;
                end else if (p_load && ld_hi != D) begin
                    wid_err++;
                end

                if (trig && !p_trig) begin
                    bit_idx = 0;
                    sout = model_val[g][0];
                    if (stress_en[g]) begin
                        st_ph = 1;
                        st_cnt = 0;
                    end
                end else if (st_ph == 1) begin
                    st_cnt++;
                    if (st_cnt == 10) begin
                        stress = 1'b1;
                        st_ph = 2;
                        st_cnt = 0;
                    end
                end else if (st_ph == 2) begin
                    st_cnt++;
                    if (st_cnt == 200) begin
                        stress = 1'b0;
                        st_ph = 0;
                    end
                end

                if (sclk2) begin
                    if (!p_clk2) begin
                        if (n_clk2 > 0 && lo2 != D) wid_err++;
                        n_clk2++;
                        hi2 = 0;
                    end
                    hi2++;
                end else begin
                    if (p_clk2) begin
                        if (hi2 != D) wid_err++;
                        lo2 = 0;
                        bit_idx++;
                        if (bit_idx < 10) sout = model_val[g][bit_idx];
                    end
                    lo2++;
                end

                if (done) begin
                    check("done_one_cycle", p_done, 0);
                    check("expected_done", (sb_q.size() > 0) ? 1 : 0, 1);
                    if (sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        check("done_lane", g, e.lane);
                        check("result", result, e.result);
                        check("model_ctrl", ctrl, e.ctrl);
                        check("timeout_flag", tflag, e.tflag);
                        check("busy_at_done", busy, 0);
                        check("fin_odo_outputs_low", outs[g][4:0], 0);
                        check("scan_clk1_pulses", n_clk1, 7);
                        check("load_pulses", n_load, 1);
                        check("scan_clk2_pulses", n_clk2, 10);
                        check("pulse_width_errors", wid_err, 0);
                        check("scan_in_unstable", sin_err, 0);
                    end
                    n_clk1 = 0; n_clk2 = 0; n_load = 0; wid_err = 0; sin_err = 0;
                    lo1 = 0; lo2 = 0;
                end

                p_clk1 = sclk1; p_clk2 = sclk2; p_load = load;
                p_trig = trig; p_sin = sin; p_done = done;
            end
        end
    end

    task automatic start_run(input int lane, input logic [6:0] c, input logic [9:0] v,
                             input logic push, input logic exp_tflag);
        exp_t x;
        cfg[lane] = c;
        model_val[lane] = v;
        if (push) begin
            x.lane = lane; x.result = v; x.ctrl = c; x.tflag = exp_tflag;
            sb_q.push_back(x);
        end
        go[lane] = 1'b1;
        @(negedge clk);
        go[lane] = 1'b0;
        check("busy_after_go", outs[lane][BBusy], 1);
    endtask

    task automatic wait_bit(input int lane, input int b, input logic val, input int budget,
                            input string name);
        int n;
        n = 0;
        while (outs[lane][b] !== val && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, (outs[lane][b] === val) ? 1 : 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            go[i] = 1'b0; cfg[i] = '0; model_val[i] = '0; stress_en[i] = 1'b1;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs_lane0", outs[0], 0);
        check("reset_result_lane0", res[0], 0);
        check("reset_outs_lane1", outs[1], 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic configure/measure/readout sequence.
        start_run(0, 7'b1010011, 10'h2A5, 1'b1, 1'b0);
        wait_bit(0, BDone, 1'b1, 2000, "run_a_done");
        @(negedge clk);
        check("busy_after_done", outs[0][BBusy], 0);

        // CFG change mid-shift, GO during READ, GO in the FIN cycle: all ignored.
        start_run(0, 7'b0110101, 10'h155, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        cfg[0] = 7'b1001010;
        wait_bit(0, BClk2, 1'b1, 2000, "run_b_read");
        go[0] = 1'b1;
        @(negedge clk);
        go[0] = 1'b0;
        wait_bit(0, BDone, 1'b1, 2000, "run_b_done");
        go[0] = 1'b1;
        @(negedge clk);
        go[0] = 1'b0;
        check("go_in_fin_ignored", outs[0][BBusy], 0);
        repeat (5) @(negedge clk);
        check("no_restart", outs[0][BBusy], 0);

        // Reset during the 5th SCAN_CLK2 pulse.
        start_run(0, 7'b1111000, 10'h3CC, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            wait_bit(0, BClk2, 1'b1, 2000, "run_c_clk2_hi");
            if (k < 4) wait_bit(0, BClk2, 1'b0, 50, "run_c_clk2_lo");
        end
        rst_n = 1'b0;
        #1;
        check("midrun_reset_outs", outs[0], 0);
        check("midrun_reset_result", res[0], 0);
        repeat (2) @(negedge clk);
        check("reset_hold_outs", outs[0], 0);
        rst_n = 1'b1;
        @(negedge clk);
        start_run(0, 7'b0000001, 10'h0F0, 1'b1, 1'b0);
        wait_bit(0, BDone, 1'b1, 2000, "run_d_done");
        @(negedge clk);

        // DIV=2 back-to-back runs, all-zero then all-one result.
        start_run(1, 7'b1000000, 10'h000, 1'b1, 1'b0);
        wait_bit(1, BDone, 1'b1, 2000, "run_e_done");
        @(negedge clk);
        start_run(1, 7'b0111111, 10'h3FF, 1'b1, 1'b0);
        wait_bit(1, BDone, 1'b1, 2000, "run_f_done");
        @(negedge clk);

`ifdef ODO_SCAN_TIMEOUT_EN
        begin
            int n;
            stress_en[0] = 1'b0;
            start_run(0, 7'b0101010, 10'h1B7, 1'b1, 1'b1);
            wait_bit(0, BTrig, 1'b1, 500, "tmo_trig_hi");
            wait_bit(0, BTrig, 1'b0, 50, "tmo_trig_lo");
            n = 0;
            while (!outs[0][BClk2] && n < 1000) begin
                @(negedge clk);
                n++;
            end
            check("tmo_wait_cycles", n, TMO + 4);
            wait_bit(0, BDone, 1'b1, 2000, "tmo_done");
            @(negedge clk);
            check("tmo_flag_held", outs[0][BTflag], 1);
            stress_en[0] = 1'b1;
            start_run(0, 7'b1100110, 10'h0C3, 1'b1, 1'b0);
            check("tmo_flag_cleared", outs[0][BTflag], 0);
            wait_bit(0, BDone, 1'b1, 2000, "tmo_next_done");
            @(negedge clk);
        end
`endif

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
